// File: rtl/seven_seg_pkg.sv
// Shared types for the seven-segment scan path: digit index, nibble, frame and blank mask.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package seven_seg_pkg;

  localparam int NUM_DIGITS_MAX = 8;

  typedef logic [2:0]  digit_idx_t;
  typedef logic [3:0]  nibble_t;
  typedef logic [31:0] frame_t;
  typedef logic [7:0]  mask_t;

  // Digit i of a frame lives in bits [4i+3:4i].
  function automatic nibble_t nibble_at(input frame_t f, input digit_idx_t i);
    return f[{i, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running slot timer: counts 0..DIV-1 and flags the terminal count.
// Latency: tc is combinational from the count register, high for one cycle every DIV cycles.
// Backpressure: none; always counts.
module refresh_prescaler #(
  parameter int  DIV = 100_000,
  localparam int CW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          tc,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  assign tc = (count == LAST);

  // Wrap to zero on terminal count so the count never exceeds DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tc) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexes an 8-nibble frame plus blank mask onto the decoder's num/sel/blank inputs.
// Latency: outputs registered, 1 cycle after state; accepted frame shown from digit 0 of the next frame.
// Backpressure: wr_ready low while a frame is pending; rises the cycle after the frame-boundary commit.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int DEAD_CYCLES = 2,
  parameter int NUM_DIGITS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_blank,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        blank,
  output logic        frame_tick
);

  localparam int              CW       = $clog2(REFRESH_DIV);
  localparam digit_idx_t      LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]   DEAD_CNT = CW'(DEAD_CYCLES);

  generate
    if (REFRESH_DIV < 2) begin : g_bad_div
      $fatal(1, "seven_seg_scan_ctrl: REFRESH_DIV must be >= 2");
    end
    if (DEAD_CYCLES < 0 || DEAD_CYCLES >= REFRESH_DIV) begin : g_bad_dead
      $fatal(1, "seven_seg_scan_ctrl: DEAD_CYCLES must be in 0..REFRESH_DIV-1");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > NUM_DIGITS_MAX) begin : g_bad_digits
      $fatal(1, "seven_seg_scan_ctrl: NUM_DIGITS must be in 1..8");
    end
  endgenerate

  logic          tc;
  logic [CW-1:0] pre_cnt;
  logic [CW-1:0] pre_cnt_next;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tc    (tc),
    .count (pre_cnt)
  );

  digit_idx_t idx;
  digit_idx_t idx_next;
  frame_t     disp_data;
  frame_t     disp_data_next;
  mask_t      disp_mask;
  mask_t      disp_mask_next;
  frame_t     pend_data;
  mask_t      pend_mask;
  logic       pend_full;
  logic       xfer;
  logic       wrap_tc;
  logic       commit;

  assign wr_ready = ~pend_full;
  assign xfer     = wr_valid & wr_ready;
  assign wrap_tc  = tc & (idx == LAST_IDX);
  // Commit looks at the registered pending flag, so a frame arriving on the wrap edge waits a full frame.
  assign commit   = wrap_tc & pend_full;

  // Post-edge view of the scan state; outputs are registered from it so they line up with the new slot.
  always_comb begin
    pre_cnt_next   = tc ? '0 : pre_cnt + CW'(1);
    idx_next       = idx;
    if (tc) begin
      idx_next = (idx == LAST_IDX) ? '0 : idx + 3'd1;
    end
    disp_data_next = commit ? pend_data : disp_data;
    disp_mask_next = commit ? pend_mask : disp_mask;
  end

  // Pending slot: single frame of lookahead, drained only at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_data <= '0;
      pend_mask <= '0;
    end else if (commit) begin
      pend_full <= 1'b0;
    end else if (xfer) begin
      pend_full <= 1'b1;
      pend_data <= wr_data;
      pend_mask <= wr_blank;
    end
  end

  // Scan index and displayed frame; display starts fully dark so nothing shows before the first commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      disp_data <= '0;
      disp_mask <= '1;
    end else begin
      idx       <= idx_next;
      disp_data <= disp_data_next;
      disp_mask <= disp_mask_next;
    end
  end

  // Decoder-facing outputs; blank also covers the first DEAD_CYCLES of every slot to hide ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num        <= '0;
      sel        <= '0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      num        <= nibble_at(disp_data_next, idx_next);
      sel        <= idx_next;
      blank      <= disp_mask_next[idx_next] | (pre_cnt_next < DEAD_CNT);
      frame_tick <= wrap_tc;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] DATA_W = 32'h1234_5678;
  localparam logic [31:0] DATA_A = 32'h89AB_CDEF;
  localparam logic [31:0] DATA_J = 32'hDEAD_BEEF;
  localparam logic [31:0] DATA_B = 32'h0246_8ACE;
  localparam logic [7:0]  MASK_B = 8'h10;
  localparam logic [31:0] DATA_C = 32'h1357_9BDF;
  localparam logic [7:0]  MASK_C = 8'h81;

  // 8-digit instance
  logic        rst8_n;
  logic        wr_valid8;
  logic        wr_ready8;
  logic [31:0] wr_data8;
  logic [7:0]  wr_blank8;
  logic [3:0]  num8;
  logic [2:0]  sel8;
  logic        blank8;
  logic        ft8;

  // 4-digit instance
  logic        rst4_n;
  logic        wr_valid4;
  logic        wr_ready4;
  logic [31:0] wr_data4;
  logic [7:0]  wr_blank4;
  logic [3:0]  num4;
  logic [2:0]  sel4;
  logic        blank4;
  logic        ft4;

  seven_seg_scan_ctrl #(.REFRESH_DIV(4), .DEAD_CYCLES(1), .NUM_DIGITS(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst8_n),
    .wr_valid   (wr_valid8),
    .wr_ready   (wr_ready8),
    .wr_data    (wr_data8),
    .wr_blank   (wr_blank8),
    .num        (num8),
    .sel        (sel8),
    .blank      (blank8),
    .frame_tick (ft8)
  );

  seven_seg_scan_ctrl #(.REFRESH_DIV(4), .DEAD_CYCLES(1), .NUM_DIGITS(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst4_n),
    .wr_valid   (wr_valid4),
    .wr_ready   (wr_ready4),
    .wr_data    (wr_data4),
    .wr_blank   (wr_blank4),
    .num        (num4),
    .sel        (sel4),
    .blank      (blank4),
    .frame_tick (ft4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the 8-digit instance shows frame_tick, bounded.
  task automatic wait_tick8();
    int n = 0;
    do begin
      step();
      n++;
    end while (ft8 !== 1'b1 && n < 100);
    if (ft8 !== 1'b1) begin
      failures++;
      $display("FAIL wait_tick8: frame_tick=%b after %0d cycles, required 1", ft8, n);
    end
    checks++;
  endtask

  task automatic test_reset();
    logic [2:0] e_sel;
    logic       e_ft;
    repeat (3) step();
    if ({blank8, sel8, num8, wr_ready8, ft8} !== {1'b1, 3'd0, 4'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: blank=%b sel=%0d num=%0d wr_ready=%b ft=%b, required 1 0 0 1 0",
               blank8, sel8, num8, wr_ready8, ft8);
    end
    checks++;
    rst8_n = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      step();
      e_sel = 3'((n % 32) / 4);
      e_ft  = (n == 32);
      if (sel8 !== e_sel || blank8 !== 1'b1 || num8 !== 4'd0 || ft8 !== e_ft) begin
        failures++;
        $display("FAIL reset_first_frame n=%0d: sel=%0d blank=%b num=%0d ft=%b, required %0d 1 0 %b",
                 n, sel8, blank8, num8, ft8, e_sel, e_ft);
      end
      checks++;
    end
  endtask

  task automatic test_write();
    logic [2:0] e_sel;
    logic [3:0] e_num;
    logic       e_blank;
    wait_tick8();
    wr_valid8 = 1'b1;
    wr_data8  = DATA_W;
    wr_blank8 = 8'h00;
    step();
    wr_valid8 = 1'b0;
    if (wr_ready8 !== 1'b0 || blank8 !== 1'b1 || num8 !== 4'd0) begin
      failures++;
      $display("FAIL write_accept: wr_ready=%b blank=%b num=%0d, required 0 1 0", wr_ready8, blank8, num8);
    end
    checks++;
    wait_tick8();
    for (int i = 0; i < 32; i++) begin
      if (i != 0) step();
      e_sel   = 3'(i / 4);
      e_num   = 4'(DATA_W >> (4 * (i / 4)));
      e_blank = (i % 4 == 0);
      if (sel8 !== e_sel || num8 !== e_num || blank8 !== e_blank || ft8 !== (i == 0) ||
          wr_ready8 !== 1'b1) begin
        failures++;
        $display("FAIL write_frame i=%0d: sel=%0d num=%h blank=%b ft=%b rdy=%b, required %0d %h %b %b 1",
                 i, sel8, num8, blank8, ft8, wr_ready8, e_sel, e_num, e_blank, (i == 0));
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e_sel;
    logic [3:0] e_num;
    logic       e_blank;
    int         n;
    wait_tick8();
    wr_valid8 = 1'b1;
    wr_data8  = DATA_A;
    wr_blank8 = 8'h00;
    step();
    // Offered while pending is full: must not be captured.
    wr_data8  = DATA_J;
    wr_blank8 = 8'hFF;
    n = 0;
    while (ft8 !== 1'b1 && n < 40) begin
      if (wr_ready8 !== 1'b0) begin
        failures++;
        $display("FAIL b2b_ready_held n=%0d: wr_ready=%b, required 0", n, wr_ready8);
      end
      checks++;
      if (n == 5) begin
        wr_data8  = DATA_B;
        wr_blank8 = MASK_B;
      end
      step();
      n++;
    end
    if (ft8 !== 1'b1 || wr_ready8 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_commit: ft=%b wr_ready=%b, required 1 1", ft8, wr_ready8);
    end
    checks++;
    for (int i = 0; i < 32; i++) begin
      if (i != 0) step();
      if (i == 1) begin
        if (wr_ready8 !== 1'b0) begin
          failures++;
          $display("FAIL b2b_second_accept: wr_ready=%b, required 0", wr_ready8);
        end
        checks++;
        wr_valid8 = 1'b0;
      end
      e_sel   = 3'(i / 4);
      e_num   = 4'(DATA_A >> (4 * (i / 4)));
      e_blank = (i % 4 == 0);
      if (sel8 !== e_sel || num8 !== e_num || blank8 !== e_blank || ft8 !== (i == 0)) begin
        failures++;
        $display("FAIL b2b_frame_a i=%0d: sel=%0d num=%h blank=%b ft=%b, required %0d %h %b %b",
                 i, sel8, num8, blank8, ft8, e_sel, e_num, e_blank, (i == 0));
      end
      checks++;
    end
    wait_tick8();
    for (int i = 0; i < 32; i++) begin
      if (i != 0) step();
      e_sel   = 3'(i / 4);
      e_num   = 4'(DATA_B >> (4 * (i / 4)));
      e_blank = MASK_B[i / 4] | (i % 4 == 0);
      if (sel8 !== e_sel || num8 !== e_num || blank8 !== e_blank || ft8 !== (i == 0)) begin
        failures++;
        $display("FAIL b2b_frame_b i=%0d: sel=%0d num=%h blank=%b ft=%b, required %0d %h %b %b",
                 i, sel8, num8, blank8, ft8, e_sel, e_num, e_blank, (i == 0));
      end
      checks++;
    end
  endtask

  task automatic test_tc_collision();
    logic [2:0] e_sel;
    logic [3:0] e_num;
    logic       e_blank;
    wait_tick8();
    repeat (31) step();
    if (sel8 !== 3'd7 || ft8 !== 1'b0 || wr_ready8 !== 1'b1) begin
      failures++;
      $display("FAIL collision_pre: sel=%0d ft=%b wr_ready=%b, required 7 0 1", sel8, ft8, wr_ready8);
    end
    checks++;
    wr_valid8 = 1'b1;
    wr_data8  = DATA_C;
    wr_blank8 = MASK_C;
    step();
    wr_valid8 = 1'b0;
    if (ft8 !== 1'b1 || wr_ready8 !== 1'b0) begin
      failures++;
      $display("FAIL collision_edge: ft=%b wr_ready=%b, required 1 0", ft8, wr_ready8);
    end
    checks++;
    // Frame just started must still show B.
    for (int i = 0; i < 32; i++) begin
      if (i != 0) step();
      e_sel   = 3'(i / 4);
      e_num   = 4'(DATA_B >> (4 * (i / 4)));
      e_blank = MASK_B[i / 4] | (i % 4 == 0);
      if (sel8 !== e_sel || num8 !== e_num || blank8 !== e_blank || wr_ready8 !== 1'b0) begin
        failures++;
        $display("FAIL collision_old_frame i=%0d: sel=%0d num=%h blank=%b rdy=%b, required %0d %h %b 0",
                 i, sel8, num8, blank8, wr_ready8, e_sel, e_num, e_blank);
      end
      checks++;
    end
    wait_tick8();
    for (int i = 0; i < 32; i++) begin
      if (i != 0) step();
      e_sel   = 3'(i / 4);
      e_num   = 4'(DATA_C >> (4 * (i / 4)));
      e_blank = MASK_C[i / 4] | (i % 4 == 0);
      if (sel8 !== e_sel || num8 !== e_num || blank8 !== e_blank || ft8 !== (i == 0)) begin
        failures++;
        $display("FAIL collision_new_frame i=%0d: sel=%0d num=%h blank=%b ft=%b, required %0d %h %b %b",
                 i, sel8, num8, blank8, ft8, e_sel, e_num, e_blank, (i == 0));
      end
      checks++;
    end
  endtask

  task automatic test_mask();
    logic [2:0] e_sel;
    logic       e_blank;
    wait_tick8();
    wr_valid8 = 1'b1;
    wr_data8  = 32'hFFFF_FFFF;
    wr_blank8 = 8'h0F;
    step();
    wr_valid8 = 1'b0;
    wait_tick8();
    for (int i = 0; i < 32; i++) begin
      if (i != 0) step();
      e_sel   = 3'(i / 4);
      e_blank = (i < 16) || (i % 4 == 0);
      if (sel8 !== e_sel || num8 !== 4'hF || blank8 !== e_blank) begin
        failures++;
        $display("FAIL mask_frame i=%0d: sel=%0d num=%h blank=%b, required %0d f %b",
                 i, sel8, num8, blank8, e_sel, e_blank);
      end
      checks++;
    end
  endtask

  task automatic test_num_digits4();
    logic [2:0] e_sel;
    logic [3:0] e_num;
    logic       e_blank;
    logic       e_ft;
    step();
    rst4_n = 1'b1;
    for (int n = 1; n <= 41; n++) begin
      step();
      e_sel   = 3'((n % 16) / 4);
      e_ft    = (n % 16 == 0);
      e_blank = (n < 16) || (n % 4 == 0);
      e_num   = (n < 16) ? 4'd0 : 4'(e_sel + 3'd1);
      if (sel4 !== e_sel || ft4 !== e_ft || blank4 !== e_blank || num4 !== e_num) begin
        failures++;
        $display("FAIL d4_scan n=%0d: sel=%0d ft=%b blank=%b num=%h, required %0d %b %b %h",
                 n, sel4, ft4, blank4, num4, e_sel, e_ft, e_blank, e_num);
      end
      checks++;
      if (n == 1) begin
        wr_valid4 = 1'b1;
        wr_data4  = 32'hFFFF_4321;
        wr_blank4 = 8'hF0;
      end
      if (n == 2) begin
        if (wr_ready4 !== 1'b0) begin
          failures++;
          $display("FAIL d4_accept: wr_ready=%b, required 0", wr_ready4);
        end
        checks++;
        wr_valid4 = 1'b0;
      end
    end
    // Mid-slot of digit 2: assert reset away from the clock edge.
    #2;
    rst4_n = 1'b0;
    #1;
    if ({blank4, sel4, num4, wr_ready4, ft4} !== {1'b1, 3'd0, 4'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL d4_async_reset: blank=%b sel=%0d num=%0d wr_ready=%b ft=%b, required 1 0 0 1 0",
               blank4, sel4, num4, wr_ready4, ft4);
    end
    checks++;
    step();
    step();
    rst4_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      e_sel = 3'((n % 16) / 4);
      e_ft  = (n == 16);
      if (sel4 !== e_sel || ft4 !== e_ft || blank4 !== 1'b1 || num4 !== 4'd0) begin
        failures++;
        $display("FAIL d4_restart n=%0d: sel=%0d ft=%b blank=%b num=%h, required %0d %b 1 0",
                 n, sel4, ft4, blank4, num4, e_sel, e_ft);
      end
      checks++;
    end
  endtask

  initial begin
    rst8_n    = 1'b0;
    wr_valid8 = 1'b0;
    wr_data8  = '0;
    wr_blank8 = '0;
    rst4_n    = 1'b0;
    wr_valid4 = 1'b0;
    wr_data4  = '0;
    wr_blank4 = '0;
    test_reset();
    test_write();
    test_back_to_back();
    test_tc_collision();
    test_mask();
    test_num_digits4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
